// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage of the Yu Core single-cycle datapath.
// Issues byte/half/word loads and stores on a ready-handshaked data bus and
// holds the core via a combinational stall until the access completes.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to flag misaligned requests
// instead of forcing them to alignment.
//
// Ports:
//   clk, rst            core clock, asynchronous active-low reset
//   req_valid/req_write load/store request, 1 = store
//   f3                  instruction funct3 (size and signedness)
//   address             effective byte address from the ALU
//   store_data          rs2 value
//   stall               combinational: hold PC/instruction while high
//   load_data           extended load result, load_valid pulses in DONE
//   misaligned          misaligned-request flag (tied 0 without the trap)
//   mem_*               data-memory bus (word-aligned address, byte strobes)
module load_store_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_write,
    input  logic [2:0]      f3,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] store_data,
    output logic            stall,
    output logic [XLEN-1:0] load_data,
    output logic            load_valid,
    output logic            misaligned,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t state_q, state_d;

    // Access attributes captured at request time for the load-lane select.
    size_t      op_size_q, op_size_d;
    logic       op_uns_q,  op_uns_d;
    logic [1:0] op_off_q,  op_off_d;

    logic            mem_req_d, mem_we_d, load_valid_d;
    logic [XLEN-1:0] mem_addr_d, mem_wdata_d, load_data_d;
    logic [3:0]      mem_wstrb_d;

    // Request decode: size, lane offset, write lanes.
    size_t           req_size;
    logic [1:0]      req_off;
    logic [XLEN-1:0] req_wdata;
    logic [3:0]      req_wstrb;

    always_comb begin
        req_size = SZ_W;
        if (req_write) begin
            unique case (f3[1:0])
                2'b00:   req_size = SZ_B;
                2'b01:   req_size = SZ_H;
                default: req_size = SZ_W;
            endcase
        end else begin
            unique case (f3)
                3'b000, 3'b100: req_size = SZ_B;
                3'b001, 3'b101: req_size = SZ_H;
                default:        req_size = SZ_W;
            endcase
        end
    end

    // Offset forced to natural alignment; misaligned requests are either
    // trapped before reaching the bus or silently aligned here.
    always_comb begin
        req_off   = 2'b00;
        req_wdata = store_data;
        req_wstrb = 4'b1111;
        unique case (req_size)
            SZ_B: begin
                req_off   = address[1:0];
                req_wdata = {4{store_data[7:0]}};
                req_wstrb = 4'b0001 << req_off;
            end
            SZ_H: begin
                req_off   = {address[1], 1'b0};
                req_wdata = {2{store_data[15:0]}};
                req_wstrb = 4'b0011 << req_off;
            end
            default: begin
                req_off   = 2'b00;
                req_wdata = store_data;
                req_wstrb = 4'b1111;
            end
        endcase
    end

    // Load lane extraction and extension from the live bus data.
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [XLEN-1:0] rd_ext;

    always_comb begin
        rd_byte = mem_rdata[{op_off_q, 3'b000} +: 8];
        rd_half = mem_rdata[{op_off_q[1], 4'b0000} +: 16];
        unique case (op_size_q)
            SZ_B:    rd_ext = {{24{~op_uns_q & rd_byte[7]}}, rd_byte};
            SZ_H:    rd_ext = {{16{~op_uns_q & rd_half[15]}}, rd_half};
            default: rd_ext = mem_rdata;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic req_mis;
    logic misaligned_d;
    assign req_mis = ((req_size == SZ_H) && address[0]) ||
                     ((req_size == SZ_W) && (address[1:0] != 2'b00));
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        op_size_d    = op_size_q;
        op_uns_d     = op_uns_q;
        op_off_d     = op_off_q;
        mem_req_d    = mem_req;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        mem_wstrb_d  = mem_wstrb;
        load_data_d  = load_data;
        load_valid_d = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_size_d   = req_size;
                    op_uns_d    = f3[2];
                    op_off_d    = req_off;
                    mem_we_d    = req_write;
                    mem_addr_d  = {address[XLEN-1:2], 2'b00};
                    mem_wdata_d = req_wdata;
                    mem_wstrb_d = req_write ? req_wstrb : 4'b0000;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (req_mis) begin
                        state_d      = DONE;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d   = BUSY;
                        mem_req_d = 1'b1;
                    end
`else
                    state_d   = BUSY;
                    mem_req_d = 1'b1;
`endif
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we) begin
                        load_valid_d = 1'b1;
                        load_data_d  = rd_ext;
                    end
                end
            end
            default: begin
                // DONE: same instruction still presents req_valid; ignore it.
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            op_size_q  <= SZ_W;
            op_uns_q   <= 1'b0;
            op_off_q   <= 2'b00;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= 4'b0000;
            load_data  <= '0;
            load_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_size_q  <= op_size_d;
            op_uns_q   <= op_uns_d;
            op_off_q   <= op_off_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            mem_wstrb  <= mem_wstrb_d;
            load_data  <= load_data_d;
            load_valid <= load_valid_d;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) misaligned <= 1'b0;
        else      misaligned <= misaligned_d;
    end
`else
    assign misaligned = 1'b0;
`endif

    // Stall covers the request cycle and every BUSY cycle, never in reset.
    assign stall = rst && (((state_q == IDLE) && req_valid) || (state_q == BUSY));

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// load/store traffic compared against a behavioural model of lane rules.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  f3 = 3'b000;
    logic [31:0] address = '0;
    logic [31:0] store_data = '0;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    load_store_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .f3(f3), .address(address), .store_data(store_data), .stall(stall),
        .load_data(load_data), .load_valid(load_valid), .misaligned(misaligned),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int rise_q[$];
    logic req_prev = 1'b0;
    logic [31:0] last_ld = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle of every mem_req rising edge, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_req && !req_prev) rise_q.push_back(cyc);
        req_prev = mem_req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One complete instruction, entered and left just after a rising edge
    // with the DUT idle. Expected behaviour comes from the lane rules only.
    task automatic access(input bit wr, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] sd, input int waits,
                          input logic [31:0] rd, input int gap);
        int          nbytes;
        int          off;
        bit          mis;
        logic [31:0] exp_wdata, exp_ld, v;
        logic [3:0]  exp_strb;

        if (wr) nbytes = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
        else    nbytes = (f == 3'd0 || f == 3'd4) ? 1 : (f == 3'd1 || f == 3'd5) ? 2 : 4;
        off = int'(a[1:0]);
        mis = (off % nbytes) != 0;
        off = off - (off % nbytes);

        exp_wdata = (nbytes == 1) ? (sd & 32'hFF) * 32'h0101_0101 :
                    (nbytes == 2) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
        exp_strb  = wr ? 4'(((1 << nbytes) - 1) << off) : 4'h0;
        v = rd >> (8 * off);
        if (nbytes == 1) begin
            v = v & 32'hFF;
            if (!f[2] && v >= 32'd128) v = v - 32'd256;
        end else if (nbytes == 2) begin
            v = v & 32'hFFFF;
            if (!f[2] && v >= 32'd32768) v = v - 32'd65536;
        end
        exp_ld = v;

        req_valid = 1'b1; req_write = wr; f3 = f; address = a; store_data = sd;
        mem_ready = 1'($urandom % 2); mem_rdata = $urandom;
        @(negedge clk);
        check("stall_req", 32'(stall), 32'd1);
        check("req_idle", 32'(mem_req), 32'd0);
        @(posedge clk); #1;

        if (TRAP && mis) begin
            mem_ready = 1'($urandom % 2); mem_rdata = $urandom;
            @(negedge clk);
            check("trap_mis", 32'(misaligned), 32'd1);
            check("trap_req", 32'(mem_req), 32'd0);
            check("trap_stall", 32'(stall), 32'd0);
            check("trap_lv", 32'(load_valid), 32'd0);
            check("trap_ld", load_data, last_ld);
        end else begin
            for (int w = 0; w <= waits; w++) begin
                mem_ready = (w == waits);
                mem_rdata = (w == waits) ? rd : $urandom;
                @(negedge clk);
                check("busy_stall", 32'(stall), 32'd1);
                check("busy_req", 32'(mem_req), 32'd1);
                check("busy_we", 32'(mem_we), 32'(wr));
                check("busy_addr", mem_addr, a & 32'hFFFF_FFFC);
                if (wr) check("busy_wdata", mem_wdata, exp_wdata);
                check("busy_wstrb", 32'(mem_wstrb), 32'(exp_strb));
                check("busy_lv", 32'(load_valid), 32'd0);
                @(posedge clk); #1;
            end
            mem_ready = 1'($urandom % 2); mem_rdata = $urandom;
            @(negedge clk);
            check("done_stall", 32'(stall), 32'd0);
            check("done_req", 32'(mem_req), 32'd0);
            check("done_lv", 32'(load_valid), 32'(!wr));
            check("done_ld", load_data, wr ? last_ld : exp_ld);
            check("done_mis", 32'(misaligned), 32'd0);
            if (!wr) last_ld = exp_ld;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            mem_ready = 1'($urandom % 2);
            @(negedge clk);
            check("gap_stall", 32'(stall), 32'd0);
            check("gap_req", 32'(mem_req), 32'd0);
            check("gap_lv", 32'(load_valid), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        // Reset held with a pending request: everything quiet.
        rst = 1'b0; req_valid = 1'b1; req_write = 1'b1; f3 = 3'b010;
        address = 32'h1234_5677; store_data = 32'hFFFF_FFFF; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_ld", load_data, 32'd0);
        check("rst_lv", 32'(load_valid), 32'd0);
        check("rst_mis", 32'(misaligned), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // LB / LBU from the top lane.
        access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h80FF_1234, 0);
        check("lb_val", load_data, 32'hFFFF_FF80);
        access(1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h80FF_1234, 1);
        check("lbu_val", load_data, 32'h0000_0080);

        // SH to the upper half with three wait states.
        access(1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 3, 32'h0, 1);
        check("sh_ld_kept", load_data, 32'h0000_0080);

        // Reset mid-BUSY of an LW drops mem_req without a clock edge.
        req_valid = 1'b1; req_write = 1'b0; f3 = 3'b010; address = 32'h40; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_req_up", 32'(mem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_req_drop", 32'(mem_req), 32'd0);
        check("mid_stall", 32'(stall), 32'd0);
        check("mid_ld", load_data, 32'd0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        last_ld = '0;

        // Misaligned LW: trapped or forced to the aligned word.
        access(1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 32'hCAFE_F00D, 1);
        check("lw101_ld", load_data, TRAP ? 32'd0 : 32'hCAFE_F00D);

        // Back-to-back LW: second request three cycles after the first.
        rise_q.delete();
        access(1'b0, 3'b010, 32'h0000_0010, 32'h0, 0, 32'h1111_2222, 0);
        access(1'b0, 3'b010, 32'h0000_0014, 32'h0, 0, 32'h3333_4444, 1);
        if (rise_q.size() < 2) check("b2b_count", 32'(rise_q.size()), 32'd2);
        else                   check("b2b_gap", 32'(rise_q[1] - rise_q[0]), 32'd3);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            bit          wr;
            logic [2:0]  f;
            wr = 1'($urandom % 2);
            f  = wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            access(wr, f, $urandom, $urandom, int'($urandom_range(0, 3)),
                   $urandom, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
